// File: rtl/otter_wb_pkg.sv
// rtl/otter_wb_pkg.sv - shared widths and queue entry type for the writeback arbiter
package otter_wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/reg_wb_arbiter_fifo.sv
// rtl/reg_wb_arbiter_fifo.sv - wb_fifo: in-order load writeback queue with per-entry address match
module wb_fifo
  import otter_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [REG_ADDR_W-1:0]   push_addr,
  input  logic [XLEN-1:0]         push_data,
  input  logic                    pop,
  output logic [REG_ADDR_W-1:0]   head_addr,
  output logic [XLEN-1:0]         head_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  input  logic [REG_ADDR_W-1:0]   chk_addr1,
  input  logic [REG_ADDR_W-1:0]   chk_addr2,
  output logic [DEPTH-1:0]        match1,
  output logic [DEPTH-1:0]        match2
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;
  logic [AW-1:0]   offs;

  // A full queue never takes a push and an empty one never pops, whatever the caller asks.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign count     = count_q;
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_addr = mem_q[rptr_q].addr;
  assign head_data = mem_q[rptr_q].data;

  // Pointer and occupancy next state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  // Pointer and occupancy registers, cleared asynchronously so reset drops all entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; validity comes from the pointers, so the data itself needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= '{addr: push_addr, data: push_data};
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    match1 = '0;
    match2 = '0;
    offs   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = AW'(i) - rptr_q;
      if ({1'b0, offs} < count_q) begin
        if ((chk_addr1 != '0) && (mem_q[i].addr == chk_addr1)) match1[i] = 1'b1;
        if ((chk_addr2 != '0) && (mem_q[i].addr == chk_addr2)) match2[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - register-file write port arbiter, ALU over queued loads; REG_WB_BYPASS_EN enables empty-queue load bypass
module reg_wb_arbiter
  import otter_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  input  logic [REG_ADDR_W-1:0]   alu_addr,
  input  logic [XLEN-1:0]         alu_data,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [REG_ADDR_W-1:0]   ld_addr,
  input  logic [XLEN-1:0]         ld_data,
  output logic                    w_en,
  output logic [REG_ADDR_W-1:0]   w_addr,
  output logic [XLEN-1:0]         w_data,
  input  logic [REG_ADDR_W-1:0]   chk_addr1,
  input  logic [REG_ADDR_W-1:0]   chk_addr2,
  output logic                    pend1,
  output logic                    pend2,
  output logic [$clog2(DEPTH):0]  q_count
);

  logic                    accept, bypass, push, pop;
  logic                    sel_valid;
  logic [REG_ADDR_W-1:0]   sel_addr;
  logic [XLEN-1:0]         sel_data;
  logic [REG_ADDR_W-1:0]   head_addr;
  logic [XLEN-1:0]         head_data;
  logic                    fifo_full, fifo_empty;
  logic [DEPTH-1:0]        match1, match2;
  logic                    w_en_q, w_en_d;
  logic [REG_ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [XLEN-1:0]         w_data_q, w_data_d;

  assign ld_ready = !fifo_full && !rst;
  assign accept   = ld_valid && ld_ready;

`ifdef REG_WB_BYPASS_EN
  assign bypass = accept && fifo_empty && !alu_valid;
`else
  assign bypass = 1'b0;
`endif

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (ld_addr),
    .push_data (ld_data),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (q_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .match1    (match1),
    .match2    (match2)
  );

  // Write-port ownership: ALU first, then queue head, then (optionally) a bypassing load.
  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    pop       = 1'b0;
    push      = accept && !bypass;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_addr  = alu_addr;
      sel_data  = alu_data;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_addr  = head_addr;
      sel_data  = head_data;
      pop       = 1'b1;
    end else if (bypass) begin
      sel_valid = 1'b1;
      sel_addr  = ld_addr;
      sel_data  = ld_data;
    end
  end

  // x0 writes are consumed but never reach the register file, so they present all zeros.
  always_comb begin
    w_en_d   = sel_valid && (sel_addr != '0);
    w_addr_d = w_en_d ? sel_addr : '0;
    w_data_d = w_en_d ? sel_data : '0;
  end

  // Registered write port with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  assign w_en   = w_en_q;
  assign w_addr = w_addr_q;
  assign w_data = w_data_q;
  assign pend1  = (|match1) && !rst;
  assign pend2  = (|match2) && !rst;

endmodule
